// File: rtl/umi_unpack_rx_if.sv
// Stream and decoded-field bundle for the UMI receive unpacker.
// slave is the unpacker's view; master is the upstream/consumer side that drives packets and out_ready.
interface umi_unpack_rx_if #(
    parameter int AW = 64,
    parameter int PW = 256
);
    logic [PW-1:0]   packet_in;
    logic            in_valid;
    logic            in_ready;
    logic            out_valid;
    logic            out_ready;
    logic [7:0]      opcode;
    logic [3:0]      size;
    logic [19:0]     user;
    logic [AW-1:0]   dstaddr;
    logic [AW-1:0]   srcaddr;
    logic [4*AW-1:0] data;
    logic            cmd_read;
    logic            cmd_write;
    logic            burst;
    logic            last;

    modport slave (
        input  packet_in, in_valid, out_ready,
        output in_ready, out_valid, opcode, size, user, dstaddr, srcaddr,
               data, cmd_read, cmd_write, burst, last
    );

    modport master (
        output packet_in, in_valid, out_ready,
        input  in_ready, out_valid, opcode, size, user, dstaddr, srcaddr,
               data, cmd_read, cmd_write, burst, last
    );
endinterface

// File: rtl/umi_unpack_rx.sv
// UMI receive unpacker: decodes header packets and tracks write bursts, with one registered output stage.
// Handshake: a packet transfers on in_valid & in_ready; outputs transfer on out_valid & out_ready.
module umi_unpack_rx #(
    parameter int AW = 64,
    parameter int PW = 256
) (
    input  logic             clk,
    input  logic             reset,
    umi_unpack_rx_if.slave   bus,
    output logic             in_burst
);

    if (AW != 64 || PW != 256) begin : g_bad_params
        $error("umi_unpack_rx supports only AW=64, PW=256");
    end

    typedef enum logic {IDLE, BURST} state_t;

    state_t        state;
    logic [10:0]   beats_left;
    logic [AW-1:0] next_addr;

    logic          accept;
    logic          hdr_read;
    logic          hdr_write;
    logic [3:0]    hdr_size;
    logic [AW-1:0] hdr_dst;

    assign bus.in_ready = ~bus.out_valid | bus.out_ready;
    assign accept       = bus.in_valid & bus.in_ready;
    assign in_burst     = (state == BURST);

    assign hdr_read  = (bus.packet_in[3:0] == 4'b1000);
    assign hdr_write = ~bus.packet_in[3];
    assign hdr_size  = bus.packet_in[11:8];
    assign hdr_dst   = {bus.packet_in[255:224], bus.packet_in[63:32]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            beats_left    <= '0;
            next_addr     <= '0;
            bus.out_valid <= 1'b0;
            bus.opcode    <= '0;
            bus.size      <= '0;
            bus.user      <= '0;
            bus.dstaddr   <= '0;
            bus.srcaddr   <= '0;
            bus.data      <= '0;
            bus.cmd_read  <= 1'b0;
            bus.cmd_write <= 1'b0;
            bus.burst     <= 1'b0;
            bus.last      <= 1'b0;
        end else begin
            if (accept) begin
                bus.out_valid <= 1'b1;
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end

            if (accept) begin
                if (state == IDLE) begin
                    bus.opcode    <= bus.packet_in[7:0];
                    bus.size      <= hdr_size;
                    bus.user      <= bus.packet_in[31:12];
                    bus.dstaddr   <= hdr_dst;
                    // Upper source word and upper data word share packet[223:192].
                    bus.srcaddr   <= {(hdr_read ? bus.packet_in[223:192] : 32'h0),
                                      bus.packet_in[95:64]};
                    bus.data      <= {128'h0,
                                      (hdr_read ? 32'h0 : bus.packet_in[223:192]),
                                      bus.packet_in[191:96]};
                    bus.cmd_read  <= hdr_read;
                    bus.cmd_write <= hdr_write;
                    bus.burst     <= 1'b0;
                    if (hdr_write && hdr_size >= 4'd5) begin
                        state      <= BURST;
                        beats_left <= 11'd1 << (hdr_size - 4'd5);
                        next_addr  <= hdr_dst + AW'(16);
                        bus.last   <= 1'b0;
                    end else begin
                        bus.last   <= 1'b1;
                    end
                end else begin
                    // Follow-on beats: opcode/size/user keep the header's values.
                    bus.dstaddr   <= next_addr;
                    bus.srcaddr   <= '0;
                    bus.data      <= {bus.packet_in[95:0], bus.packet_in[255:96]};
                    bus.cmd_read  <= 1'b0;
                    bus.cmd_write <= 1'b0;
                    bus.burst     <= 1'b1;
                    next_addr     <= next_addr + AW'(32);
                    beats_left    <= beats_left - 11'd1;
                    if (beats_left == 11'd1) begin
                        bus.last <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        bus.last <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_umi_unpack_rx.sv
// Self-checking bench for umi_unpack_rx: transaction-level model with an expected-beat queue.
module tb_umi_unpack_rx;

    logic clk;
    logic reset;
    logic in_burst;
    logic rand_ready_en;
    int   checks;
    int   failures;

    umi_unpack_rx_if #(.AW(64), .PW(256)) bus ();

    umi_unpack_rx #(.AW(64), .PW(256)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .in_burst (in_burst)
    );

    typedef struct packed {
        logic [7:0]   opcode;
        logic [3:0]   size;
        logic [19:0]  user;
        logic [63:0]  dst;
        logic [63:0]  src;
        logic [255:0] data;
        logic         rd;
        logic         wr;
        logic         bst;
        logic         lst;
    } exp_t;

    exp_t exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        if (rand_ready_en) begin
            #1;
            bus.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Every output handshake must match the oldest expected beat.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("opcode",    bus.opcode,    e.opcode);
                check("size",      bus.size,      e.size);
                check("user",      bus.user,      e.user);
                check("dstaddr",   bus.dstaddr,   e.dst);
                check("srcaddr",   bus.srcaddr,   e.src);
                check("data",      bus.data,      e.data);
                check("cmd_read",  bus.cmd_read,  e.rd);
                check("cmd_write", bus.cmd_write, e.wr);
                check("burst",     bus.burst,     e.bst);
                check("last",      bus.last,      e.lst);
            end
        end
    end

    task automatic send_pkt(input logic [255:0] p);
        int  t;
        logic acc;
        bus.in_valid  = 1'b1;
        bus.packet_in = p;
        t = 0;
        do begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            t++;
        end while (!acc && t < 200);
        if (!acc) check("send_timeout", 0, 1);
        bus.in_valid = 1'b0;
    endtask

    task automatic idle_gap(input int max_gap);
        int n;
        n = $urandom_range(0, max_gap);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 1000) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    // Header plus up to max_beats follow-on beats; expected beats come from transaction arithmetic.
    task automatic send_txn(input logic [7:0] op, input logic [3:0] sz, input logic [19:0] usr,
                            input logic [63:0] dst, input logic [63:0] src,
                            input logic [127:0] d, input int max_beats, input int max_gap);
        logic [255:0] p;
        logic [255:0] bd;
        exp_t         e;
        logic         is_rd;
        logic         is_wr;
        int           n;
        is_rd = (op[3:0] == 4'h8);
        is_wr = !op[3];
        n = (is_wr && sz >= 4'd5) ? (1 << (int'(sz) - 5)) : 0;

        p = '0;
        p[31:0]    = {usr, sz, op};
        p[63:32]   = dst[31:0];
        p[255:224] = dst[63:32];
        p[95:64]   = src[31:0];
        p[191:96]  = d[95:0];
        p[223:192] = is_rd ? src[63:32] : d[127:96];

        e.opcode = op;
        e.size   = sz;
        e.user   = usr;
        e.dst    = dst;
        e.src    = is_rd ? src : {32'h0, src[31:0]};
        e.data   = is_rd ? {160'h0, d[95:0]} : {128'h0, d};
        e.rd     = is_rd;
        e.wr     = is_wr;
        e.bst    = 1'b0;
        e.lst    = (n == 0);
        exp_q.push_back(e);
        send_pkt(p);

        for (int k = 0; k < n && k < max_beats; k++) begin
            idle_gap(max_gap);
            for (int i = 0; i < 8; i++) bd[i*32 +: 32] = $urandom;
            p = {bd[159:0], bd[255:160]};
            e.dst  = dst + 64'd16 + 64'(32 * k);
            e.src  = '0;
            e.data = bd;
            e.rd   = 1'b0;
            e.wr   = 1'b0;
            e.bst  = 1'b1;
            e.lst  = (k == n - 1);
            exp_q.push_back(e);
            send_pkt(p);
        end
    endtask

    function automatic logic [127:0] rand128();
        logic [127:0] r;
        for (int i = 0; i < 4; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    initial begin
        logic [7:0]  op;
        logic [3:0]  sz;
        logic [63:0] a_dst;
        logic [127:0] a_d;

        checks        = 0;
        failures      = 0;
        reset         = 1'b1;
        rand_ready_en = 1'b0;
        bus.in_valid  = 1'b0;
        bus.packet_in = '0;
        bus.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready",  bus.in_ready,  1);
        check("rst_dstaddr",   bus.dstaddr,   0);
        check("rst_data",      bus.data,      0);
        check("rst_opcode",    bus.opcode,    0);
        check("rst_last",      bus.last,      0);
        check("rst_burst",     bus.burst,     0);
        check("rst_in_burst",  in_burst,      0);
        @(posedge clk);
        #1;
        reset         = 1'b0;
        bus.out_ready = 1'b1;
        rand_ready_en = 1'b1;

        // Single write with one-cycle latency
        send_txn(8'h01, 4'd3, 20'h12345, 64'h0000_0001_0000_1000, 64'h0000_0000_5555_6666,
                 128'h0F0E0D0C0B0A09080706050403020100, 99, 0);
        check("latency_valid", bus.out_valid, 1);
        wait_drain();

        // Read stays in IDLE even with a large size
        send_txn(8'h08, 4'd9, 20'h0ABCD, 64'h0000_0000_2000_0000, 64'hAAAA_BBBB_CCCC_DDDD,
                 rand128(), 99, 0);
        check("read_idle", in_burst, 0);
        wait_drain();

        // Size-6 burst at 0x1000, then a header
        send_txn(8'h01, 4'd6, 20'h00001, 64'h1000, 64'h77, rand128(), 99, 2);
        wait_drain();
        check("burst_done_idle", in_burst, 0);
        send_txn(8'h05, 4'd2, 20'h00002, 64'h3000, 64'h88, rand128(), 99, 0);
        wait_drain();

        // Address wrap-around
        send_txn(8'h01, 4'd5, 20'h00003, 64'hFFFF_FFFF_FFFF_FFE0, 64'h1, rand128(), 99, 1);
        send_txn(8'h01, 4'd6, 20'h00004, 64'hFFFF_FFFF_FFFF_FFE0, 64'h2, rand128(), 99, 1);
        wait_drain();

        // Backpressure: outputs must freeze while out_ready is low
        rand_ready_en = 1'b0;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        a_dst = 64'h0000_0042_0000_0100;
        a_d   = rand128();
        send_txn(8'h01, 4'd2, 20'h00005, a_dst, 64'h3, a_d, 99, 0);
        fork
            send_txn(8'h11, 4'd1, 20'h00006, 64'h0000_0000_0000_0200, 64'h4, rand128(), 99, 0);
            begin
                repeat (5) begin
                    @(negedge clk);
                    check("bp_in_ready",  bus.in_ready,  0);
                    check("bp_out_valid", bus.out_valid, 1);
                    check("bp_dstaddr",   bus.dstaddr,   a_dst);
                    check("bp_data",      bus.data,      {128'h0, a_d});
                end
                @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        wait_drain();
        rand_ready_en = 1'b1;

        // Reset after the first beat of a size-7 burst
        send_txn(8'h01, 4'd7, 20'h00007, 64'h0000_0000_0000_4000, 64'h5, rand128(), 1, 0);
        wait_drain();
        check("mid_burst_active", in_burst, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("mrst_out_valid", bus.out_valid, 0);
        check("mrst_dstaddr",   bus.dstaddr,   0);
        check("mrst_data",      bus.data,      0);
        check("mrst_burst",     bus.burst,     0);
        check("mrst_in_burst",  in_burst,      0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        send_txn(8'h03, 4'd4, 20'h00008, 64'h0000_0000_0000_5000, 64'h6, rand128(), 99, 0);
        wait_drain();

        // Randomized transactions
        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 3))
                0, 1: begin
                    op = 8'($urandom) & 8'hF7;
                    sz = 4'($urandom_range(0, 8));
                end
                2: begin
                    op = {4'($urandom), 4'h8};
                    sz = 4'($urandom_range(0, 15));
                end
                default: begin
                    op = {4'($urandom), 4'(9 + $urandom_range(0, 6))};
                    sz = 4'($urandom_range(0, 15));
                end
            endcase
            send_txn(op, sz, 20'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                     rand128(), 99, 2);
            idle_gap(2);
        end
        wait_drain();

        repeat (3) @(posedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
